// File: rtl/fsm_prog_pkg.sv
`default_nettype none
// ============================================================================
// fsm_prog_pkg
// Shared definitions for the Controller programming path (serializer and
// deserializer), fixing entry order and bit order for both ends.
// Revision: 1.0
// ============================================================================
package fsm_prog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } prog_state_t;

    // Entries are state-major, input-minor: one entry per (state, input) pair.
    function automatic int entry_count(input int state_count, input int input_width);
        return state_count << input_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_prog_serializer_shift_reg.sv
`default_nettype none
// ============================================================================
// fsm_prog_serializer_shift_reg
// Parallel-load, shift-right register with bit counter and last-bit flag.
// Revision: 1.0
// ============================================================================
module fsm_prog_serializer_shift_reg #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             bit_out,
    output logic             last_bit
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (clear) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shreg <= load_data;
            r_cnt   <= '0;
        end else if (shift) begin
            r_shreg <= r_shreg >> 1;
            r_cnt   <= r_cnt + c_CNT_W'(1);
        end
    end

    // The register is cleared whenever the stream pauses, so bit 0 is the
    // serial output directly and reads 0 outside of shifting.
    assign bit_out  = r_shreg[0];
    assign last_bit = (r_cnt == c_CNT_W'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/fsm_prog_serializer.sv
`default_nettype none
// ============================================================================
// fsm_prog_serializer
// Writer side of the Controller programming interface: accepts table entries
// over valid/ready and shifts them LSB-first onto prog_data/prog_enable.
// Revision: 1.0
// ============================================================================
module fsm_prog_serializer
    import fsm_prog_pkg::*;
#(
    parameter int  STATE_COUNT = 8,
    parameter int  INPUT_WIDTH = 4,
    localparam int STATE_WIDTH = $clog2(STATE_COUNT),
    localparam int ENTRY_COUNT = entry_count(STATE_COUNT, INPUT_WIDTH),
    localparam int IDX_WIDTH   = $clog2(ENTRY_COUNT)
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   word_valid,
    input  logic [STATE_WIDTH-1:0] word_data,
    output logic                   word_ready,
    output logic                   prog_enable,
    output logic                   prog_data,
    output logic [IDX_WIDTH-1:0]   entry_idx,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] c_IDLE  = IDLE;
    localparam logic [1:0] c_LOAD  = LOAD;
    localparam logic [1:0] c_SHIFT = SHIFT;
    localparam logic [1:0] c_DONE  = DONE;

    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(ENTRY_COUNT - 1);

    logic [1:0]           r_state;
    logic                 r_prog_enable;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_last_entry;
    logic [IDX_WIDTH-1:0] r_entry_idx;

    logic w_last_bit;
    logic w_word_ready;
    logic w_handshake;
    logic w_abort;
    logic w_load;
    logic w_shift;
    logic w_clear;

    // Ready on the final bit too, so consecutive entries stream with no gap.
    assign w_word_ready = (r_state == c_LOAD) ||
                          ((r_state == c_SHIFT) && w_last_bit && !r_last_entry);
    assign w_handshake  = word_valid && w_word_ready;
    assign w_abort      = abort && (r_state != c_IDLE);

    always_comb begin
        w_clear = 1'b0;
        w_load  = 1'b0;
        w_shift = 1'b0;
        if (w_abort) begin
            w_clear = 1'b1;
        end else if (w_handshake) begin
            w_load = 1'b1;
        end else if (r_state == c_SHIFT) begin
            if (w_last_bit) begin
                w_clear = 1'b1;
            end else begin
                w_shift = 1'b1;
            end
        end
    end

    fsm_prog_serializer_shift_reg #(
        .WIDTH (STATE_WIDTH)
    ) u_shift_reg (
        .clock     (clock),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .load      (w_load),
        .load_data (word_data),
        .shift     (w_shift),
        .bit_out   (prog_data),
        .last_bit  (w_last_bit)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_prog_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_last_entry  <= 1'b0;
            r_entry_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state       <= c_IDLE;
                r_prog_enable <= 1'b0;
                r_busy        <= 1'b0;
                r_last_entry  <= 1'b0;
                r_entry_idx   <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (start) begin
                            r_state      <= c_LOAD;
                            r_busy       <= 1'b1;
                            r_last_entry <= 1'b0;
                            r_entry_idx  <= '0;
                        end
                    end
                    c_LOAD, c_SHIFT: begin
                        if (w_handshake) begin
                            r_state       <= c_SHIFT;
                            r_prog_enable <= 1'b1;
                            // The index parks on the final entry; only start rewinds it.
                            if (r_entry_idx == c_LAST_IDX) begin
                                r_last_entry <= 1'b1;
                            end else begin
                                r_entry_idx <= r_entry_idx + IDX_WIDTH'(1);
                            end
                        end else if ((r_state == c_SHIFT) && w_last_bit) begin
                            r_prog_enable <= 1'b0;
                            if (r_last_entry) begin
                                r_state <= c_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= c_LOAD;
                            end
                        end
                    end
                    c_DONE: begin
                        r_state <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign word_ready  = w_word_ready;
    assign prog_enable = r_prog_enable;
    assign entry_idx   = r_entry_idx;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: doc/fsm_prog_serializer.md
Name: fsm_prog_serializer

Overview:
- Writer side of the Controller's serial programming interface.
- Accepts transition-table entries as parallel words over a valid/ready handshake.
- Serializes each entry LSB-first onto prog_data, qualified by prog_enable, until the full table has been shifted.
- Sits between a host or loader and the Controller's prog_enable/prog_data inputs; reports busy, entry progress and completion.

Parameters:
- STATE_COUNT, 8, number of FSM states in the target Controller.
- INPUT_WIDTH, 4, width of the Controller input vector.
- STATE_WIDTH, $clog2(STATE_COUNT), bits per next-state entry (localparam).
- ENTRY_COUNT, STATE_COUNT << INPUT_WIDTH (128 by default), table entries per program (localparam).

Ports:
- clock  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a programming pass; honoured only in IDLE.
- abort  in  1  synchronous cancel of the current pass.
- word_valid  in  1  upstream entry available.
- word_data  in  STATE_WIDTH  next-state entry. Entry order is state-major, input-minor.
- word_ready  out  1  block accepts word_data this cycle.
- prog_enable  out  1  prog_data holds a valid bit this cycle.
- prog_data  out  1  serial bit.
- entry_idx  out  $clog2(ENTRY_COUNT)  index of the next entry to accept.
- busy  out  1  high from start acceptance until done or abort.
- done  out  1  one-cycle pulse after the last bit of the last entry.

Behaviour:
- Reset value of every output is 0; FSM is in IDLE.
- All outputs are registered, except word_ready, which decodes the FSM state and shift counter only.
- Reset asserted mid-pass discards the pass. There is no done and no partial recovery.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 → LOAD; busy=1 next cycle; entry_idx cleared to 0.
- LOAD:
  - word_ready=1.
  - On word_valid & word_ready, capture word_data into the shift register → SHIFT.
  - With no word_valid, stay in LOAD with prog_enable=0 (stall; Controller samples nothing).
- SHIFT:
  - Each cycle: prog_enable=1, prog_data=shreg[0]; shift right; bit counter increments 0..STATE_WIDTH-1.
  - Latency: a word accepted in cycle N drives bit 0 in cycle N+1 and bit STATE_WIDTH-1 in cycle N+STATE_WIDTH.
  - word_ready is also 1 during the last bit cycle, unless this is the last entry. A handshake in that cycle reloads the shift register, so the next word's bit 0 follows with no gap.
  - Last bit with no handshake → LOAD.
  - entry_idx increments on each accepted word. It wraps only via a new start.
- Last bit of entry ENTRY_COUNT-1 → DONE:
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- start while busy is ignored.
- word_valid in IDLE or DONE is ignored; word_ready=0 there.
- abort, any state other than IDLE:
  - Next cycle: IDLE, prog_enable=0, busy=0, no done.
  - Shift register and counters cleared.
  - abort and start together in IDLE: start wins.
- prog_data is 0 whenever prog_enable=0.

Decomposition:
- Shared package fsm_prog_pkg:
  - state enum prog_state_t {IDLE, LOAD, SHIFT, DONE}.
  - Function to compute ENTRY_COUNT from STATE_COUNT and INPUT_WIDTH.
  - Package is shared with the Controller's deserializer so both ends agree on entry order and bit order.
- Optional sub-module prog_shift_reg: parallel-load, shift-right register with bit counter and a last-bit flag.
- FSM and entry counter stay in the top.

Test Plan:
1. Back-to-back load:
   - Stimulus: reset, start, word_valid held high with word_data = entry_idx[2:0] for 128 words.
   - Response: prog_enable high for 384 consecutive cycles; done pulses exactly once, one cycle after the last bit; busy falls with done.
2. Bit order:
   - Stimulus: single word 3'b110 at entry 0.
   - Response: prog_data sequence 0,1,1 with prog_enable=1; entry_idx goes 0→1 on acceptance.
3. Upstream stall:
   - Stimulus: drop word_valid for 5 cycles after entry 3.
   - Response: prog_enable=0 and prog_data=0 for those 5 cycles, word_ready=1 throughout; shifting resumes one cycle after word_valid returns.
4. Abort mid-entry:
   - Stimulus: abort during bit 1 of entry 10.
   - Response: next cycle prog_enable=0, busy=0, no done.
   - Follow-up: a new start restarts at entry_idx=0.
5. Ignored start:
   - Stimulus: pulse start at entry 50.
   - Response: no change to entry_idx or the bit stream; done still after entry 127.
6. Async reset:
   - Stimulus: assert rst_n=0 mid-SHIFT, between clock edges.
   - Response: all outputs 0 immediately; after release, state is IDLE and word_ready=0.
